// File: rtl/clk_ce_if.sv
// clk_ce_if: increment/enable controls into clk_ce_gen and the enables and reset it produces.
interface clk_ce_if #(parameter int NUM_CH = 3, parameter int ACC_W = 32);
  logic [NUM_CH*ACC_W-1:0] inc;
  logic                    inc_load;
  logic [NUM_CH-1:0]       ch_en;
  logic                    phase_clr;
  logic [NUM_CH-1:0]       ce;
  logic                    sys_rst_n;
  logic                    ready;
  modport master (output inc, inc_load, ch_en, phase_clr, input ce, sys_rst_n, ready);
  modport slave (input inc, inc_load, ch_en, phase_clr, output ce, sys_rst_n, ready);
endinterface

// File: rtl/clk_ce_gen.sv
// clk_ce_gen: PLL lock qualifier, reset sequencer and phase-accumulator clock-enable generator.
module clk_ce_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input logic   refclk,
  input logic   rst_n,
  input logic   pll_locked,
  clk_ce_if.slave bus
);
  localparam int CW = $clog2(LOCK_CYCLES);
  typedef enum logic [1:0] {HOLD, WAIT_LOCK, COUNT, RUN} state_t;
  state_t                       state_q, state_d;
  logic [1:0]                   sync_q;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d, inc_q, inc_d;
  logic [NUM_CH-1:0]            ce_q, ce_d;
  logic                         rdy_q, rdy_d, locked_s, adv;
  assign locked_s = sync_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      HOLD:      state_d = WAIT_LOCK;
      WAIT_LOCK: state_d = locked_s ? COUNT : WAIT_LOCK;
      COUNT: begin
        state_d = !locked_s ? WAIT_LOCK : (cnt_q == CW'(LOCK_CYCLES - 1)) ? RUN : COUNT;
        cnt_d   = locked_s ? cnt_q + 1'b1 : '0;
      end
      default:   state_d = locked_s ? RUN : WAIT_LOCK;
    endcase
    // accumulators only advance while RUN persists across the edge and no clear is pending
    adv   = (state_q == RUN) && (state_d == RUN) && !bus.phase_clr;
    rdy_d = state_d == RUN;
    inc_d = bus.inc_load ? bus.inc : inc_q;
    ce_d  = '0;
    acc_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      {ce_d[k], acc_d[k]} = adv ? {1'b0, acc_q[k]} + {1'b0, inc_q[k]} : '0;
      ce_d[k] = ce_d[k] & bus.ch_en[k];
    end
  end
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      sync_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      inc_q   <= '0;
      ce_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], pll_locked};
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      ce_q    <= ce_d;
      rdy_q   <= rdy_d;
    end
  end
  assign bus.ce        = ce_q;
  assign bus.ready     = rdy_q;
  assign bus.sys_rst_n = rdy_q;
endmodule

// File: tb/tb_clk_ce_gen.sv
// tb_clk_ce_gen: randomized scoreboard bench for clk_ce_gen against a lock-streak / carry-count model.
module tb_clk_ce_gen;
  localparam int N = 3, W = 32, L = 16;
  logic refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0;
  clk_ce_if #(.NUM_CH(N), .ACC_W(W)) bus ();
  clk_ce_gen #(.NUM_CH(N), .ACC_W(W), .LOCK_CYCLES(L)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .bus(bus)
  );
  always #5 refclk = ~refclk;
  typedef struct packed {logic [N-1:0] ce; logic rdy; logic srn;} obs_t;
  obs_t            q[$];
  int              vectors = 0, errors = 0;
  int              cnt[N];
  logic            h1 = 0, h2 = 0, held = 1, run = 0;
  int              streak = 0;
  longint unsigned base[N], n[N], sh[N];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_in(input string name, input longint act, input longint lo, input longint hi);
    vectors++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic model_reset();
    h1 = 0; h2 = 0; held = 1; run = 0; streak = 0;
    for (int k = 0; k < N; k++) begin base[k] = 0; n[k] = 0; sh[k] = 0; end
  endtask
  // release needs L+1 consecutive synchronised-lock edges after the first post-reset edge;
  // pulses are the increments of floor(phase / 2^W) since the last phase origin
  task automatic model_step();
    logic ls, nr, add, c;
    logic [N-1:0] ce_e;
    longint unsigned s0, s1;
    ls = h2; h2 = h1; h1 = pll_locked;
    if (held) begin held = 0; nr = 0; end
    else begin
      nr = ls && streak >= L;
      streak = !ls ? 0 : (streak < L) ? streak + 1 : L;
    end
    add = run && nr && !bus.phase_clr;
    for (int k = 0; k < N; k++) begin
      c = 0;
      if (add) begin
        n[k]++;
        s1 = base[k] + n[k] * sh[k];
        s0 = s1 - sh[k];
        c = (s1 >> W) != (s0 >> W);
      end else begin base[k] = 0; n[k] = 0; end
      if (bus.inc_load) begin
        base[k] = (base[k] + n[k] * sh[k]) % (64'd1 << W);
        n[k] = 0;
        sh[k] = bus.inc[k*W +: W];
      end
      ce_e[k] = c & bus.ch_en[k];
    end
    run = nr;
    q.push_back({ce_e, nr, nr});
  endtask
  initial forever begin
    @(posedge refclk);
    if (!rst_n) begin model_reset(); q.push_back('0); end
    else model_step();
  end
  initial forever begin
    @(negedge rst_n);
    model_reset();
    foreach (q[i]) q[i] = '0;
  end
  initial begin
    obs_t e;
    forever begin
      @(negedge refclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("outputs{ce,ready,sys_rst_n}", {bus.ce, bus.ready, bus.sys_rst_n}, e);
      end
    end
  end
  task automatic cyc(input int c);
    repeat (c) @(posedge refclk);
    #1;
  endtask
  task automatic wait_rdy(input logic lvl, input int budget, output int e);
    e = 0;
    while (bus.ready !== lvl && e < budget) begin cyc(1); e++; end
  endtask
  task automatic count_ce(input int cycles);
    for (int k = 0; k < N; k++) cnt[k] = 0;
    repeat (cycles) begin
      cyc(1);
      for (int k = 0; k < N; k++) cnt[k] += int'(bus.ce[k]);
    end
  endtask
  task automatic load(input logic [N*W-1:0] v, input logic clr);
    bus.inc = v; bus.inc_load = 1; bus.phase_clr = clr;
    cyc(1);
    bus.inc_load = 0; bus.phase_clr = 0;
  endtask
  initial begin
    int e;
    bus.inc = '0; bus.inc_load = 0; bus.ch_en = '1; bus.phase_clr = 0;
    cyc(3);
    rst_n = 1;
    chk("reset_ready", bus.ready, 0);
    chk("reset_sys_rst_n", bus.sys_rst_n, 0);
    chk("reset_ce", bus.ce, 0);
    load({32'd0, 32'h4000_0000, 32'h8000_0000}, 0);
    cyc(3);
    pll_locked = 1;
    wait_rdy(1, 100, e);
    chk("lock_latency", e, 19);
    count_ce(4000);
    chk_in("rate_ce0", cnt[0], 1999, 2001);
    chk_in("rate_ce1", cnt[1], 999, 1001);
    chk("rate_ce2", cnt[2], 0);
    pll_locked = 0;
    wait_rdy(0, 20, e);
    chk("loss_latency", e, 3);
    cyc(5);
    pll_locked = 1;
    cyc(13);
    pll_locked = 0;
    cyc(1);
    pll_locked = 1;
    wait_rdy(1, 100, e);
    chk_in("glitch_release", 14 + e, 30, 100);
    cyc(3);
    load({32'd0, 32'h8000_0000, 32'h8000_0000}, 0);
    bus.ch_en = 3'b101;
    cyc(3);
    bus.ch_en = 3'b111;
    cyc(2);
    bus.phase_clr = 1;
    cyc(1);
    bus.phase_clr = 0;
    for (int i = 0; i < 10; i++) begin
      chk("phase_align", bus.ce[1:0], (i >= 2 && i % 2 == 0) ? 2'b11 : 2'b00);
      cyc(1);
    end
    bus.ch_en = 3'b101;
    count_ce(8);
    chk("ch_en_ce0", cnt[0], 4);
    chk("ch_en_ce1", cnt[1], 0);
    bus.ch_en = 3'b111;
    load({32'd0, 32'd0, 32'd1803886264}, 1);
    count_ce(50000);
    chk_in("rate_042", cnt[0], 20999, 21001);
    repeat (3000) begin
      if ($urandom_range(49) == 0) begin
        for (int k = 0; k < N; k++)
          bus.inc[k*W +: W] = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
        bus.inc_load = 1;
      end
      bus.phase_clr = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) bus.ch_en = N'($urandom);
      if ($urandom_range(299) == 0) pll_locked = ~pll_locked;
      cyc(1);
      bus.inc_load = 0; bus.phase_clr = 0;
    end
    pll_locked = 1;
    bus.ch_en = '1;
    wait_rdy(1, 200, e);
    chk("random_relock", bus.ready, 1);
    load({32'd0, 32'd0, 32'hFFFF_FFFF}, 1);
    cyc(2);
    count_ce(100);
    chk("max_inc_ce0", cnt[0], 100);
    rst_n = 0;
    #1;
    chk("async_rst_ce", bus.ce, 0);
    chk("async_rst_ready", bus.ready, 0);
    chk("async_rst_sys_rst_n", bus.sys_rst_n, 0);
    cyc(3);
    rst_n = 1;
    wait_rdy(1, 100, e);
    chk("relock_latency", e, 19);
    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/clk_ce_gen.md
# clk_ce_gen

Multi-channel clock-enable generator and reset sequencer that sits directly behind the board PLL in the nes_strigeus clock tree. It qualifies the PLL `locked` flag, releases a synchronised system reset only after lock has been stable for a programmable interval, and then derives up to NUM_CH fractional-rate clock-enable pulses from the PLL output using phase accumulators. This replaces per-frequency PLL instances: CPU, PPU and APU rates become enables on one clock.

## Interface
- NUM_CH, 3: number of enable channels (1..8).
- ACC_W, 32: phase-accumulator / increment width in bits (8..48).
- LOCK_CYCLES, 1024: consecutive synchronised-locked cycles required before reset release (≥2).
- refclk  in  1: sole clock (PLL output clock).
- rst_n  in  1: asynchronous, active-low reset.
- pll_locked  in  1: PLL lock flag, asynchronous to refclk.
- inc  in  NUM_CH*ACC_W: per-channel increment words; channel k at [k*ACC_W +: ACC_W].
- inc_load  in  1: one-cycle strobe; latches all of `inc` into shadow registers.
- ch_en  in  NUM_CH: per-channel enable; low forces that channel's ce to 0, accumulator keeps running.
- phase_clr  in  1: one-cycle strobe; clears all accumulators together.
- ce  out  NUM_CH: one-cycle clock-enable pulses.
- sys_rst_n  out  1: downstream reset, active-low, async assert, sync deassert.
- ready  out  1: high while in RUN.

## Operation
- pll_locked passes through a 2-flop synchroniser (reset to 0) → locked_s.
- FSM states: HOLD, WAIT_LOCK, COUNT, RUN. rst_n low → HOLD asynchronously.
- HOLD → WAIT_LOCK unconditionally on first edge after rst_n release.
- WAIT_LOCK: lock counter = 0; locked_s=1 → COUNT.
- COUNT: counter increments each locked_s=1 cycle; locked_s=0 → WAIT_LOCK (counter cleared). Counter == LOCK_CYCLES-1 with locked_s=1 → RUN.
- RUN: locked_s=0 → WAIT_LOCK immediately; sys_rst_n, ready, ce all drop on that edge.
- sys_rst_n = registered (next_state == RUN); ready identical. Both 0 in every state except RUN.
- Shadow increment registers reset to 0; inc_load updates them in any state; new value used from the cycle after the strobe. Accumulator phase is not disturbed by inc_load.
- Accumulators: held at 0 outside RUN and on the RUN entry edge. In RUN: {carry, acc} = acc + inc_shadow (ACC_W+1 bits); acc takes low ACC_W bits, carry discarded into ce.
- ce[k] = registered (carry[k] & ch_en[k] & state==RUN). Output rate = f_refclk · inc / 2^ACC_W. inc=0 → no pulses; inc=2^ACC_W-1 → pulse every cycle except once per 2^ACC_W.
- phase_clr in RUN: all accumulators load 0 on next edge (that cycle's add discarded, no carry); all channels restart phase-aligned. Ignored outside RUN (already 0). phase_clr and inc_load together: both take effect; accumulators clear, new increments apply next cycle.

## Timing
- Reset values: ce=0, sys_rst_n=0, ready=0, acc=0, inc_shadow=0, lock counter=0, state=HOLD.
- pll_locked rise to sys_rst_n rise: 2 (sync) + 1 (HOLD→WAIT_LOCK if still pending) + 1 (WAIT→COUNT) + LOCK_CYCLES edges; bench checks exact count from a clean start: sys_rst_n high on the LOCK_CYCLES+3rd edge after pll_locked rises (HOLD already left).
- Lock loss: sys_rst_n low 3 edges after pll_locked falls (2 sync + 1 state).
- Let R0 = first cycle with ready=1. acc=inc after R0 edge. First ce for channel with inc ≥ 2^(ACC_W-1) occurs no earlier than R2.
- rst_n low mid-RUN: all outputs 0 asynchronously, no glitch on ce.

## Test plan
- NUM_CH=3, LOCK_CYCLES=16; pll_locked rises after reset → sys_rst_n/ready rise exactly 19 edges later; ce stays 0 throughout.
- pll_locked drops for 1 cycle at count 10 → counter restarts; release delayed by ≥11 cycles vs. clean case.
- inc0=2^31, inc1=2^30, inc2=0 (ACC_W=32) → ce0 every 2 cycles starting R2, ce1 every 4 cycles starting R4, ce2 never; over 4000 cycles counts 2000/1000/0 ±1.
- inc0=round(0.42·2^32)=1803886264, 10^6 cycles → 420000 ±1 pulses (21 MHz from 50 MHz).
- phase_clr mid-RUN with inc0=inc1=2^31 misaligned by ch_en toggling → pulses coincide from 2 cycles after strobe; ch_en[1]=0 suppresses ce1 only.
- pll_locked falls in RUN → sys_rst_n, ready, ce low 3 edges later; rst_n pulse mid-RUN → immediate async clear of all outputs.
